// File: rtl/fprint_ptr_bank_n_pkg.sv
// fprint_ptr_bank_n_pkg: shared FSM encoding and default widths for the fingerprint pointer bank
package fprint_ptr_bank_n_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SET, S_SET_ACK, S_INC, S_CLR, S_RST} state_e;
  localparam int DEF_NUM_CORES = 2;
  localparam int DEF_NUM_TASKS = 16;
  localparam int DEF_ADDR_W = 10;
  function automatic int core_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fprint_ptr_bank_n_core.sv
// fprint_ptr_bank_n_core: one core's head/tail arrays, ready bits and write-first comparator read registers
module fprint_ptr_bank_n_core
  import fprint_ptr_bank_n_pkg::*;
#(
  parameter int NUM_TASKS = DEF_NUM_TASKS,
  parameter int TASK_W = $clog2(NUM_TASKS),
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              set_we_i,
  input  logic [TASK_W-1:0] set_task_i,
  input  logic [ADDR_W-1:0] set_data_i,
  input  logic              inc_we_i,
  input  logic              rdy_set_i,
  input  logic [TASK_W-1:0] fp_task_i,
  input  logic [ADDR_W-1:0] start_ex_i,
  input  logic [ADDR_W-1:0] end_ex_i,
  input  logic              rst_we_i,
  input  logic              clr_i,
  input  logic              tail_inc_i,
  input  logic [TASK_W-1:0] comp_task_i,
  input  logic [ADDR_W-1:0] start_comp_i,
  input  logic [ADDR_W-1:0] end_comp_i,
  output logic [ADDR_W-1:0] fp_head_rd_o,
  output logic [ADDR_W-1:0] fp_head_nxt_o,
  output logic [ADDR_W-1:0] fp_tail_o,
  output logic [ADDR_W-1:0] comp_head_o,
  output logic [ADDR_W-1:0] comp_tail_o,
  output logic              tail_at_head_o,
  output logic [NUM_TASKS-1:0] ready_o
);
  logic [ADDR_W-1:0] head_q [NUM_TASKS];
  logic [ADDR_W-1:0] head_d [NUM_TASKS];
  logic [ADDR_W-1:0] tail_q [NUM_TASKS];
  logic [ADDR_W-1:0] tail_d [NUM_TASKS];
  logic [NUM_TASKS-1:0] ready_q, ready_d;
  logic [ADDR_W-1:0] comp_head_q, comp_tail_q, tail_nxt;
  assign fp_head_nxt_o = head_q[fp_task_i] == end_ex_i ? start_ex_i : head_q[fp_task_i] + 1'b1;
  assign tail_nxt = tail_q[comp_task_i] == end_comp_i ? start_comp_i : tail_q[comp_task_i] + 1'b1;
  assign tail_at_head_o = comp_tail_q == comp_head_q;
  assign fp_head_rd_o = head_d[fp_task_i];
  assign fp_tail_o = tail_q[fp_task_i];
  assign comp_head_o = comp_head_q;
  assign comp_tail_o = comp_tail_q;
  assign ready_o = ready_q;
  // next-state arrays; later writes win, giving tail priority SET > advance > task reset
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    ready_d = ready_q;
    if (rst_we_i) begin
      head_d[comp_task_i] = start_comp_i;
      tail_d[comp_task_i] = start_comp_i;
      ready_d[comp_task_i] = 1'b0;
    end
    if (clr_i && tail_at_head_o) ready_d[comp_task_i] = 1'b0;
    if (inc_we_i) head_d[fp_task_i] = fp_head_nxt_o;
    if (rdy_set_i) ready_d[fp_task_i] = 1'b1;
    if (tail_inc_i) tail_d[comp_task_i] = tail_nxt;
    if (set_we_i) begin
      head_d[set_task_i] = set_data_i;
      tail_d[set_task_i] = set_data_i;
    end
  end
  // pointer storage is deliberately unreset; software loads it with SET
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end
  // ready bits and write-first comparator read registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ready_q <= '0;
      comp_head_q <= '0;
      comp_tail_q <= '0;
    end else begin
      ready_q <= ready_d;
      comp_head_q <= head_d[comp_task_i];
      comp_tail_q <= tail_d[comp_task_i];
    end
  end
endmodule

// File: rtl/fprint_ptr_bank_n.sv
// fprint_ptr_bank_n: N-core fingerprint head/tail pointer bank; FPRINT_OVERFLOW_EN enables head-over-tail protection
module fprint_ptr_bank_n
  import fprint_ptr_bank_n_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int NUM_TASKS = DEF_NUM_TASKS,
  parameter int TASK_W = $clog2(NUM_TASKS),
  parameter int CORE_W = core_w(NUM_CORES),
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        set_req_i,
  input  logic [CORE_W-1:0]           set_core_i,
  input  logic [TASK_W-1:0]           set_task_i,
  input  logic [ADDR_W-1:0]           set_data_i,
  output logic                        set_ack_o,
  input  logic [CORE_W-1:0]           fp_core_i,
  input  logic [TASK_W-1:0]           fp_task_i,
  output logic [ADDR_W-1:0]           fp_head_o,
  input  logic                        fp_inc_req_i,
  output logic                        fp_inc_ack_o,
  input  logic [ADDR_W-1:0]           start_ex_i,
  input  logic [ADDR_W-1:0]           end_ex_i,
  input  logic [ADDR_W-1:0]           start_comp_i,
  input  logic [ADDR_W-1:0]           end_comp_i,
  input  logic [TASK_W-1:0]           comp_task_i,
  output logic [NUM_CORES*ADDR_W-1:0] comp_head_o,
  output logic [NUM_CORES*ADDR_W-1:0] comp_tail_o,
  output logic                        heads_match_o,
  output logic [NUM_CORES-1:0]        tail_at_head_o,
  input  logic                        comp_inc_tail_i,
  input  logic                        clr_rdy_req_i,
  output logic                        clr_rdy_ack_o,
  input  logic                        rst_task_req_i,
  output logic                        rst_task_ack_o,
  output logic [NUM_TASKS-1:0]        ready_out_o,
  output logic [NUM_CORES-1:0]        overflow_o
);
`ifdef FPRINT_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  state_e state_q;
  logic set_ack_q, inc_ack_q, clr_ack_q, rst_ack_q;
  logic [ADDR_W-1:0] fp_head_q;
  logic [ADDR_W-1:0] fp_rd [NUM_CORES];
  logic [ADDR_W-1:0] fp_nxt [NUM_CORES];
  logic [ADDR_W-1:0] fp_tail [NUM_CORES];
  logic [NUM_TASKS-1:0] rdy [NUM_CORES];
  logic [NUM_CORES-1:0] eq, blk;
  logic idle, take_set, take_inc, take_clr, take_rst;
  assign idle = state_q == S_IDLE;
  assign take_set = idle && set_req_i;
  assign take_inc = idle && !set_req_i && fp_inc_req_i;
  assign take_clr = idle && !set_req_i && !fp_inc_req_i && clr_rdy_req_i;
  assign take_rst = idle && !set_req_i && !fp_inc_req_i && !clr_rdy_req_i && rst_task_req_i;
  assign set_ack_o = set_ack_q;
  assign fp_inc_ack_o = inc_ack_q;
  assign clr_rdy_ack_o = clr_ack_q;
  assign rst_task_ack_o = rst_ack_q;
  assign fp_head_o = fp_head_q;
  assign heads_match_o = &eq;
  // request arbiter; each ack is high exactly while its named state is held
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      set_ack_q <= 1'b0;
      inc_ack_q <= 1'b0;
      clr_ack_q <= 1'b0;
      rst_ack_q <= 1'b0;
    end else begin
      state_q <= take_set ? S_SET : take_inc ? S_INC : take_clr ? S_CLR : take_rst ? S_RST :
                 state_q == S_SET ? S_SET_ACK : S_IDLE;
      set_ack_q <= state_q == S_SET;
      inc_ack_q <= take_inc;
      clr_ack_q <= take_clr;
      rst_ack_q <= take_rst;
    end
  end
  // fingerprint-side read register, fed by the selected core's post-write head
  always_ff @(posedge clk_i) begin
    if (reset_i) fp_head_q <= '0;
    else fp_head_q <= fp_rd[fp_core_i];
  end
  // a task is ready only once every redundant core has produced fingerprints for it
  always_comb begin
    ready_out_o = '1;
    for (int i = 0; i < NUM_CORES; i++) ready_out_o = ready_out_o & rdy[i];
  end
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic sel;
    assign sel = fp_core_i == CORE_W'(c);
    assign blk[c] = OVF_EN && fp_nxt[c] == fp_tail[c];
    assign eq[c] = comp_head_o[c*ADDR_W +: ADDR_W] == comp_head_o[ADDR_W-1:0];
    fprint_ptr_bank_n_core #(.NUM_TASKS(NUM_TASKS), .TASK_W(TASK_W), .ADDR_W(ADDR_W)) u_core (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .set_we_i(state_q == S_SET && set_core_i == CORE_W'(c)),
      .set_task_i(set_task_i),
      .set_data_i(set_data_i),
      .inc_we_i(state_q == S_INC && sel && !blk[c]),
      .rdy_set_i(state_q == S_INC && sel),
      .fp_task_i(fp_task_i),
      .start_ex_i(start_ex_i),
      .end_ex_i(end_ex_i),
      .rst_we_i(state_q == S_RST),
      .clr_i(state_q == S_CLR),
      .tail_inc_i(comp_inc_tail_i),
      .comp_task_i(comp_task_i),
      .start_comp_i(start_comp_i),
      .end_comp_i(end_comp_i),
      .fp_head_rd_o(fp_rd[c]),
      .fp_head_nxt_o(fp_nxt[c]),
      .fp_tail_o(fp_tail[c]),
      .comp_head_o(comp_head_o[c*ADDR_W +: ADDR_W]),
      .comp_tail_o(comp_tail_o[c*ADDR_W +: ADDR_W]),
      .tail_at_head_o(tail_at_head_o[c]),
      .ready_o(rdy[c])
    );
`ifdef FPRINT_OVERFLOW_EN
    logic ovf_q;
    logic [TASK_W-1:0] ovf_task_q;
    assign overflow_o[c] = ovf_q;
    // sticky full flag, remembering which task tripped it so only that task's reset clears it
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        ovf_q <= 1'b0;
        ovf_task_q <= '0;
      end else if (state_q == S_INC && sel && blk[c]) begin
        ovf_q <= 1'b1;
        ovf_task_q <= fp_task_i;
      end else if (state_q == S_RST && comp_task_i == ovf_task_q) begin
        ovf_q <= 1'b0;
      end
    end
`else
    assign overflow_o[c] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_fprint_ptr_bank_n.sv
// tb_fprint_ptr_bank_n: directed checks of the 3-core pointer bank
module tb_fprint_ptr_bank_n;
  localparam int NC = 3, NT = 16, TW = 4, CW = 2, AW = 10;
  logic clk = 1'b0;
  logic reset, set_req, fp_inc_req, comp_inc_tail, clr_rdy_req, rst_task_req;
  logic set_ack, fp_inc_ack, clr_rdy_ack, rst_task_ack, heads_match;
  logic [CW-1:0] set_core, fp_core;
  logic [TW-1:0] set_task, fp_task, comp_task;
  logic [AW-1:0] set_data, fp_head, start_ex, end_ex, start_comp, end_comp;
  logic [NC*AW-1:0] comp_head, comp_tail;
  logic [NC-1:0] tail_at_head, overflow;
  logic [NT-1:0] ready_out;
  int checks = 0, passed = 0, fails = 0, lat;
  always #5 clk = ~clk;
  fprint_ptr_bank_n #(.NUM_CORES(NC), .NUM_TASKS(NT), .ADDR_W(AW)) dut (
    .clk_i(clk), .reset_i(reset), .set_req_i(set_req), .set_core_i(set_core), .set_task_i(set_task),
    .set_data_i(set_data), .set_ack_o(set_ack), .fp_core_i(fp_core), .fp_task_i(fp_task),
    .fp_head_o(fp_head), .fp_inc_req_i(fp_inc_req), .fp_inc_ack_o(fp_inc_ack), .start_ex_i(start_ex),
    .end_ex_i(end_ex), .start_comp_i(start_comp), .end_comp_i(end_comp), .comp_task_i(comp_task),
    .comp_head_o(comp_head), .comp_tail_o(comp_tail), .heads_match_o(heads_match),
    .tail_at_head_o(tail_at_head), .comp_inc_tail_i(comp_inc_tail), .clr_rdy_req_i(clr_rdy_req),
    .clr_rdy_ack_o(clr_rdy_ack), .rst_task_req_i(rst_task_req), .rst_task_ack_o(rst_task_ack),
    .ready_out_o(ready_out), .overflow_o(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic ack_of(input int k);
    return k == 0 ? set_ack : k == 1 ? fp_inc_ack : k == 2 ? clr_rdy_ack : rst_task_ack;
  endfunction
  // raise one request, wait (bounded) for its ack, check latency, drop it and let the FSM return to idle
  task automatic serve(input int k, input string tag);
    int n;
    n = 0;
    case (k)
      0: set_req = 1'b1;
      1: fp_inc_req = 1'b1;
      2: clr_rdy_req = 1'b1;
      default: rst_task_req = 1'b1;
    endcase
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(k) && n < 20);
    chk({tag, " ack latency"}, n, k == 0 ? 2 : 1);
    set_req = 1'b0;
    fp_inc_req = 1'b0;
    clr_rdy_req = 1'b0;
    rst_task_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_set(input int c, input int t, input logic [AW-1:0] d);
    set_core = CW'(c);
    set_task = TW'(t);
    set_data = d;
    serve(0, "set");
  endtask
  task automatic do_inc(input int c, input int t);
    fp_core = CW'(c);
    fp_task = TW'(t);
    serve(1, "inc");
  endtask
  task automatic pulse_tail();
    comp_inc_tail = 1'b1;
    @(negedge clk);
    comp_inc_tail = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    {set_req, fp_inc_req, comp_inc_tail, clr_rdy_req, rst_task_req} = '0;
    set_core = '0; set_task = '0; set_data = '0; fp_core = '0; fp_task = '0;
    start_ex = 10'h040; end_ex = 10'h07F; start_comp = 10'h040; end_comp = 10'h0FF;
    comp_task = 4'd3;
    repeat (3) @(negedge clk);
    chk("reset acks", {set_ack, fp_inc_ack, clr_rdy_ack, rst_task_ack}, 0);
    chk("reset ready_out", ready_out, 0);
    chk("reset overflow", overflow, 0);
    chk("reset fp_head", fp_head, 0);
    chk("reset comp_head", comp_head, 0);
    chk("reset comp_tail", comp_tail, 0);
    reset = 1'b0;
    @(negedge clk);
    do_set(1, 3, 10'h040);
    chk("set comp_head[1]", comp_head[AW +: AW], 10'h040);
    chk("set comp_tail[1]", comp_tail[AW +: AW], 10'h040);
    do_set(0, 3, 10'h07F);
    fp_core = 2'd0; fp_task = 4'd3;
    @(negedge clk);
    chk("fp_head before wrap", fp_head, 10'h07F);
    do_inc(0, 3);
    chk("fp_head wrap end_ex", fp_head, 10'h040);
    chk("ready_out one core", ready_out, 0);
    do_set(1, 3, 10'h050);
    do_set(2, 3, 10'h060);
    do_inc(1, 3);
    chk("fp_head core1", fp_head, 10'h051);
    chk("ready_out two cores", ready_out, 0);
    do_inc(2, 3);
    chk("fp_head core2", fp_head, 10'h061);
    chk("ready_out all cores", ready_out, 16'h0008);
    comp_task = 4'd2;
    for (int c = 0; c < NC; c++) do_set(c, 2, 10'h044);
    chk("match after set", heads_match, 1);
    chk("tail_at_head after set", tail_at_head, 3'b111);
    for (int c = 0; c < NC; c++) do_inc(c, 2);
    chk("match after inc all", heads_match, 1);
    chk("comp_head[2] inc", comp_head[2*AW +: AW], 10'h045);
    chk("tail_at_head after inc", tail_at_head, 3'b000);
    chk("ready_out tasks 2,3", ready_out, 16'h000C);
    do_inc(0, 2);
    chk("match after extra inc", heads_match, 0);
    chk("comp_head[0] extra inc", comp_head[AW-1:0], 10'h046);
    pulse_tail();
    chk("tail advance all", comp_tail, {10'h045, 10'h045, 10'h045});
    chk("tail_at_head partial", tail_at_head, 3'b110);
    serve(2, "clr");
    chk("clr drained cores", ready_out, 16'h0008);
    do_inc(1, 2);
    do_inc(2, 2);
    chk("clr kept core0 ready", ready_out, 16'h000C);
    chk("match realigned", heads_match, 1);
    set_core = 2'd1; set_task = 4'd2; set_data = 10'h0FF; set_req = 1'b1;
    @(negedge clk);
    comp_inc_tail = 1'b1;
    @(negedge clk);
    comp_inc_tail = 1'b0;
    chk("conflict set_ack", set_ack, 1);
    set_req = 1'b0;
    @(negedge clk);
    chk("set beats tail inc", comp_tail, {10'h046, 10'h0FF, 10'h046});
    chk("conflict comp_head[1]", comp_head[AW +: AW], 10'h0FF);
    pulse_tail();
    chk("tail wrap end_comp", comp_tail, {10'h047, 10'h040, 10'h047});
    serve(3, "rst");
    chk("rst heads", comp_head, {3{10'h040}});
    chk("rst tails", comp_tail, {3{10'h040}});
    chk("rst ready", ready_out, 16'h0008);
    chk("rst tail_at_head", tail_at_head, 3'b111);
    comp_task = 4'd5;
    do_set(0, 5, 10'h04F);
    pulse_tail();
    chk("ovf setup tail", comp_tail[AW-1:0], 10'h050);
    do_inc(0, 5);
`ifdef FPRINT_OVERFLOW_EN
    chk("ovf head held", fp_head, 10'h04F);
    chk("ovf flag", overflow, 3'b001);
    serve(3, "rst ovf");
    chk("ovf cleared by rst", overflow, 3'b000);
`else
    chk("no ovf head wraps", fp_head, 10'h050);
    chk("no ovf flag", overflow, 3'b000);
`endif
    fp_core = 2'd1; fp_task = 4'd3;
    reset = 1'b1;
    fp_inc_req = 1'b1;
    @(negedge clk);
    chk("mid-reset no ack a", fp_inc_ack, 0);
    @(negedge clk);
    chk("mid-reset no ack b", fp_inc_ack, 0);
    chk("mid-reset ready", ready_out, 0);
    reset = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!fp_inc_ack && lat < 20);
    chk("post-reset inc latency", lat, 1);
    fp_inc_req = 1'b0;
    @(negedge clk);
    chk("post-reset inc head", fp_head, 10'h052);
    chk("post-reset ready", ready_out, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
